uncache_unit: RTL and testbench

UNCACHE_UNIT -- requirements
Module: uncache_unit

---
 rtl/uncache_unit.sv | 132 +++++++++++++
 tb/tb_uncache_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_unit.sv
// Uncached load/store unit: turns one MEM2-stage request into a single bus
// read (AR/R) or write (AW/W/B) transaction and stalls the pipeline until it completes.
module uncache_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_paddr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata_bus,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata_bus,
  output logic [3:0]  wstrb_bus,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic [2:0]  state_dbg
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both 1.
  // Every valid/ready output is a flop, so none depends combinationally on a bus
  // input; a raised valid holds with a stable payload until its own beat transfers.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        wr_q;
  logic        arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
  logic        accept;
  logic        capture;
  logic [1:0]  size_eff;

  assign accept  = (state_q == IDLE) && req_valid;
  assign capture = (state_q == RDATA) && rvalid && !wr_q;

  always_comb begin
    state_d   = state_q;
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    bready_d  = 1'b0;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_wr ? WREQ : RADDR;
      RADDR:   if (arready) state_d = RDATA;
      RDATA:   if (rvalid) state_d = DONE;
      // AW and W complete independently; leave once neither is still pending.
      WREQ:    if ((!awvalid || awready) && (!wvalid || wready)) state_d = WRESP;
      WRESP:   if (bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    arvalid_d = (state_d == RADDR);
    rready_d  = (state_d == RDATA);
    bready_d  = (state_d == WRESP);
    awvalid_d = (accept && req_wr) || ((state_q == WREQ) && awvalid && !awready);
    wvalid_d  = (accept && req_wr) || ((state_q == WREQ) && wvalid && !wready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      arvalid <= arvalid_d;
      rready  <= rready_d;
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      bready  <= bready_d;
      if (accept) begin
        addr_q  <= req_paddr;
        size_q  <= req_size;
        wstrb_q <= req_wstrb;
        wdata_q <= req_wdata;
        wr_q    <= req_wr;
      end
      if (capture) rdata <= rdata_bus;
    end
  end

  // Size code 3 has no wider meaning on this bus and is sent as a word.
  assign size_eff  = (size_q == 2'd3) ? 2'd2 : size_q;
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arsize    = {1'b0, size_eff};
  assign awsize    = {1'b0, size_eff};
  assign wdata_bus = wdata_q;
  assign wstrb_bus = wstrb_q;

  assign data_ok   = (state_q == DONE);
  assign stall     = accept || (state_q == RADDR) || (state_q == RDATA) ||
                     (state_q == WREQ) || (state_q == WRESP);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uncache_unit.sv
// Bench for uncache_unit: randomized requests against a delay-programmable bus
// slave, with a queue-based scoreboard and a latency model derived from bus delays.
module tb_uncache_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_paddr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        stall, data_ok;
  logic [31:0] rdata, araddr, awaddr, wdata_bus;
  logic [2:0]  arsize, awsize, state_dbg;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  wstrb_bus;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata_bus = '0;

  always #5 clk = ~clk;

  uncache_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_paddr(req_paddr),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .stall(stall), .data_ok(data_ok), .rdata(rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata_bus(rdata_bus), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata_bus(wdata_bus), .wstrb_bus(wstrb_bus), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .state_dbg(state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] exp_q[$];  // {is_load, load data} per expected data_ok
  logic [34:0] ar_q[$];   // {bus size, address}
  logic [34:0] aw_q[$];
  logic [35:0] w_q[$];    // {wstrb, wdata}

  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  bit bb = 0;
  bit held_ok = 0;
  logic [31:0] last_load = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Device memory seen by loads.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1FAF_F000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [2:0] bus_size(input logic [1:0] s);
    return (s == 2'd3) ? 3'd2 : {1'b0, s};
  endfunction

  // ---------------- bus slave (decides ready/valid on the falling edge) ----------------
  logic [31:0] r_addr = '0, ar_prev = '0, aw_prev = '0;
  logic [35:0] w_prev = '0;
  bit r_pend = 0, aw_done = 0, w_done = 0;
  bit ar_hold = 0, aw_hold = 0, w_hold = 0, ar_hs = 0, aw_hs = 0, w_hs = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  initial begin : slave
    logic [34:0] ea;
    logic [35:0] ew;
    forever begin
      @(negedge clk);
      if (!rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        r_pend = 0; aw_done = 0; w_done = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_hold = 0; aw_hold = 0; w_hold = 0; ar_hs = 0; aw_hs = 0; w_hs = 0;
      end else begin
        if (ar_hold) begin check("arvalid_held", arvalid, 1); check("araddr_stable", araddr, ar_prev); end
        if (ar_hs) check("arvalid_drop", arvalid, 0);
        if (aw_hold) begin check("awvalid_held", awvalid, 1); check("awaddr_stable", awaddr, aw_prev); end
        if (aw_hs) check("awvalid_drop", awvalid, 0);
        if (w_hold) begin check("wvalid_held", wvalid, 1); check("w_stable", {wstrb_bus, wdata_bus}, w_prev); end
        if (w_hs) check("wvalid_drop", wvalid, 0);

        arready = 0; ar_hold = 0; ar_hs = 0;
        if (arvalid) begin
          if (ar_cnt >= ar_dly) begin
            arready = 1; ar_hs = 1; ar_cnt = 0;
            if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
            else begin
              ea = ar_q.pop_front();
              check("araddr", araddr, ea[31:0]);
              check("arsize", arsize, ea[34:32]);
            end
            r_addr = araddr; r_pend = 1; r_cnt = 0;
          end else begin ar_cnt++; ar_hold = 1; ar_prev = araddr; end
        end

        rvalid = 0; rdata_bus = $urandom;
        if (r_pend && rready) begin
          if (r_cnt >= r_dly) begin rvalid = 1; rdata_bus = mem_word(r_addr); r_pend = 0; end
          else r_cnt++;
        end

        awready = 0; aw_hold = 0; aw_hs = 0;
        if (awvalid) begin
          if (aw_cnt >= aw_dly) begin
            awready = 1; aw_hs = 1; aw_cnt = 0; aw_done = 1;
            if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
            else begin
              ea = aw_q.pop_front();
              check("awaddr", awaddr, ea[31:0]);
              check("awsize", awsize, ea[34:32]);
            end
          end else begin aw_cnt++; aw_hold = 1; aw_prev = awaddr; end
        end

        wready = 0; w_hold = 0; w_hs = 0;
        if (wvalid) begin
          if (w_cnt >= w_dly) begin
            wready = 1; w_hs = 1; w_cnt = 0; w_done = 1;
            if (w_q.size() == 0) check("w_unexpected", 1, 0);
            else begin
              ew = w_q.pop_front();
              check("w_beat", {wstrb_bus, wdata_bus}, ew);
            end
          end else begin w_cnt++; w_hold = 1; w_prev = {wstrb_bus, wdata_bus}; end
        end

        bvalid = 0;
        if (aw_done && w_done && bready) begin
          if (b_cnt >= b_dly) begin bvalid = 1; aw_done = 0; w_done = 0; b_cnt = 0; end
          else b_cnt++;
        end
      end
    end
  end

  // ---------------- monitor: pops the scoreboard on every data_ok ----------------
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (data_ok) begin
        check("stall_in_done", stall, 0);
        if (exp_q.size() == 0) check("data_ok_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (e[32]) check("rdata", rdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    req_valid = 0; rst = 0;
    repeat (2) @(negedge clk);
    exp_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
    rst = 1; bb = 0; held_ok = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 0; bb = 0;
    repeat (n) begin
      @(negedge clk);
      check("stall_idle", stall, 0);
      if (held_ok) check("rdata_held", rdata, last_load);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of the DONE cycle.
  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd, input bit scramble);
    int cyc, lat, wmax;
    wmax = (aw_dly > w_dly) ? aw_dly : w_dly;
    lat  = 3 + (bb ? 1 : 0) + (wr ? (wmax + b_dly) : (ar_dly + r_dly));
    req_valid = 1; req_wr = wr; req_size = size; req_paddr = addr; req_wstrb = strb; req_wdata = wd;
    exp_q.push_back({!wr, wr ? 32'h0 : mem_word(addr)});
    if (wr) begin
      aw_q.push_back({bus_size(size), addr});
      w_q.push_back({strb, wd});
    end else ar_q.push_back({bus_size(size), addr});
    #1 check("stall_on_request", stall, bb ? 0 : 1);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (data_ok || cyc >= 300) break;
      check("stall_busy", stall, 1);
      if (scramble && cyc >= (bb ? 2 : 1)) begin
        req_wr = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
        req_paddr = $urandom; req_wstrb = 4'($urandom_range(0, 15)); req_wdata = $urandom;
      end
    end
    if (!data_ok) begin
      check("timeout_data_ok", 0, 1);
      reset_dut();
      return;
    end
    check("latency", cyc, lat);
    if (!wr) begin last_load = mem_word(addr); held_ok = 1; end
    else held_ok = 0;
    bb = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc;
    #2 rst = 0;
    repeat (2) @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_data_ok", data_ok, 0);
    check("rst_rdata", rdata, 0);
    check("rst_araddr", araddr, 0);
    check("rst_wdata_bus", wdata_bus, 0);
    check("rst_stall_noreq", stall, 0);
    req_valid = 1; #1 check("rst_stall_req", stall, 1);
    req_valid = 0;
    @(negedge clk);
    rst = 1;
    idle(2);

    // Load word, arready after 2 cycles, rvalid after 3.
    ar_dly = 2; r_dly = 3;
    issue(1'b0, 2'd2, 32'h1FAF_F000, 4'hF, 32'h0, 1'b0);
    idle(2);

    // Store byte; awready one cycle ahead of wready.
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 1; b_dly = 1;
    issue(1'b1, 2'd0, 32'h1FAF_F001, 4'b0010, 32'h0000_AB00, 1'b0);
    idle(1);

    // Store with everything ready at once.
    aw_dly = 0; w_dly = 0; b_dly = 0;
    issue(1'b1, 2'd2, 32'h1FAF_F010, 4'hF, 32'h1234_5678, 1'b0);
    idle(1);

    // Back-to-back load then store with req_valid held through DONE.
    issue(1'b0, 2'd1, 32'h0000_0402, 4'h3, 32'h0, 1'b0);
    issue(1'b1, 2'd3, 32'h0000_0800, 4'hF, 32'hCAFE_F00D, 1'b0);
    idle(1);

    // Request inputs toggled while the read address is pending.
    ar_dly = 3; r_dly = 1;
    issue(1'b0, 2'd2, 32'h0BAD_0004, 4'hF, 32'h0, 1'b1);
    idle(1);

    // Reset while waiting in the read-data phase.
    ar_dly = 0; r_dly = 1000;
    req_valid = 1; req_wr = 0; req_size = 2'd2; req_paddr = 32'h0000_1230;
    ar_q.push_back({3'd2, 32'h0000_1230});
    cyc = 0;
    while (!rready && cyc < 10) begin @(negedge clk); cyc++; end
    check("reached_rdata", rready, 1);
    req_valid = 0; rst = 0;
    #1;
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_bready", bready, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_stall", stall, 0);
    repeat (2) begin @(negedge clk); check("mid_rst_data_ok", data_ok, 0); end
    rst = 1; r_dly = 0; held_ok = 0; bb = 0;
    idle(2);
    issue(1'b0, 2'd0, 32'h0000_1231, 4'h1, 32'h0, 1'b0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(4);

    check("exp_q_drained", exp_q.size(), 0);
    check("ar_q_drained", ar_q.size(), 0);
    check("aw_q_drained", aw_q.size(), 0);
    check("w_q_drained", w_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
